// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, shifter mode encodings, instruction field positions.
// Used by the execute-stage decode and by the bench.
// No ports; types and localparams only.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int RID_W  = 4;

    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRA = 2'b01,
        MODE_ROR = 2'b10
    } shift_mode_e;

    // instruction: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] imm4
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    function automatic logic is_shift_op(input logic [3:0] opc);
        return (opc == OP_SLL) || (opc == OP_SRA) || (opc == OP_ROR);
    endfunction

endpackage

// File: rtl/Shifter.sv
// 16-bit combinational barrel shifter: SLL zero-fill, SRA sign-fill, ROR rotate right.
// Ports: Shift_In data, Shift_Val amount 0..15, Mode select, Shift_Out result.
// Purely combinational; no clock, no backpressure.
module Shifter (
    input  logic [15:0] Shift_In,
    input  logic [3:0]  Shift_Val,
    input  logic [1:0]  Mode,
    output logic [15:0] Shift_Out
);

    logic [31:0] rot_wide;

    // Rotating a doubled copy right leaves the rotated word in the low half.
    assign rot_wide = {Shift_In, Shift_In} >> Shift_Val;

    always_comb begin
        Shift_Out = Shift_In;
        case (Mode)
            2'b00:   Shift_Out = Shift_In << Shift_Val;
            2'b01:   Shift_Out = $unsigned($signed(Shift_In) >>> Shift_Val);
            2'b10:   Shift_Out = rot_wide[15:0];
            default: Shift_Out = Shift_In;
        endcase
    end

endmodule

// File: rtl/shift_ex_stage.sv
// Execute stage for SLL/SRA/ROR: decodes the ID/EX payload, shifts, registers result/rd/Z into one EX/MEM slot.
// Ports: in_valid/in_ready + instr/rs_data upstream, out_valid/out_ready + out_data/out_rd/z_flag downstream, flush squash.
// Latency 1 cycle; in_ready = !out_valid | out_ready, so a full slot stalls upstream until drained (1/cycle throughput).
module shift_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int RID_W  = cpu_pkg::RID_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RID_W-1:0]  out_rd,
    output logic              z_flag
);

    logic [3:0]        opcode;
    logic [1:0]        mode;
    logic              is_shift;
    logic              accept;
    logic [15:0]       shift_out;
    logic              unused_rs_field;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [RID_W-1:0]  out_rd_q,    out_rd_d;
    logic              z_q,         z_d;

    assign opcode   = instr[OPC_MSB:OPC_LSB];
    assign is_shift = is_shift_op(opcode);

    // rs index is resolved upstream; only its forwarded value matters here.
    assign unused_rs_field = ^instr[RS_MSB:RS_LSB];

    always_comb begin
        mode = MODE_SLL;
        case (opcode)
            OP_SRA:  mode = MODE_SRA;
            OP_ROR:  mode = MODE_ROR;
            default: mode = MODE_SLL;
        endcase
    end

    Shifter u_shifter (
        .Shift_In  (rs_data),
        .Shift_Val (instr[IMM_MSB:IMM_LSB]),
        .Mode      (mode),
        .Shift_Out (shift_out)
    );

    assign in_ready = !out_valid_q || out_ready;
    // Non-shift opcodes are consumed as bubbles: they pass the handshake but never write.
    assign accept   = in_valid && in_ready && is_shift && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        z_d         = z_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = shift_out;
            out_rd_d    = instr[RD_MSB:RD_LSB];
            z_d         = (shift_out == '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            z_q         <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            z_q         <= z_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign z_flag    = z_q;

endmodule

// File: tb/tb_shift_ex_stage.sv
module tb_shift_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] rs_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_rd;
    logic        z_flag;

    int total = 0;
    int bad   = 0;

    // reference slot contents
    logic        m_vld;
    logic [15:0] m_data;
    logic [3:0]  m_rd;
    logic        m_z;

    always #5 clk = ~clk;

    shift_ex_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_data   (rs_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .z_flag    (z_flag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] imm);
        return {op, rd, 4'h0, imm};
    endfunction

    // Shift results computed arithmetically rather than with shift operators on 16-bit vectors.
    function automatic logic [15:0] ref_shift(input logic [3:0] op, input logic [15:0] a, input int n);
        int ua, s, p, r;
        ua = int'(a);
        p  = 1 << n;
        r  = ua;
        case (op)
            4'h4: r = (ua * p) % 65536;
            4'h5: begin
                s = (ua >= 32768) ? ua - 65536 : ua;
                if (s < 0) r = (s - (p - 1)) / p;   // floor division for negatives
                else       r = s / p;
                r = r & 32'hFFFF;
            end
            4'h6: r = ((ua / p) + (ua % p) * (65536 / p)) % 65536;
            default: r = ua;
        endcase
        return r[15:0];
    endfunction

    task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] rs,
                        input logic fl, input logic ordy);
        logic [3:0]  op;
        logic        rdy, take;
        logic [15:0] res;
        in_valid  = v;
        instr     = ins;
        rs_data   = rs;
        flush     = fl;
        out_ready = ordy;
        #1;
        rdy = !m_vld || ordy;
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        op   = ins[15:12];
        take = v && rdy && !fl && (op == 4'h4 || op == 4'h5 || op == 4'h6);
        res  = ref_shift(op, rs, int'(ins[3:0]));
        if (fl) begin
            m_vld = 1'b0;
        end else if (take) begin
            m_vld  = 1'b1;
            m_data = res;
            m_rd   = ins[11:8];
            m_z    = (res == 16'h0);
        end else if (ordy) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_vld});
        if (m_vld) begin
            chk("out_data", {16'b0, out_data}, {16'b0, m_data});
            chk("out_rd", {28'b0, out_rd}, {28'b0, m_rd});
        end
        chk("z_flag", {31'b0, z_flag}, {31'b0, m_z});
    endtask

    initial begin
        logic [15:0] held_data;
        logic        held_z;
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs_data = '0; flush = 1'b0; out_ready = 1'b0;
        m_vld = 1'b0; m_data = '0; m_rd = '0; m_z = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", {16'b0, out_data}, 32'd0);
        chk("rst_rd", {28'b0, out_rd}, 32'd0);
        chk("rst_z", {31'b0, z_flag}, 32'd0);
        rst_n = 1'b1;

        step(1'b1, mk(4'h4, 4'h3, 4'd4), 16'h0001, 1'b0, 1'b1);
        chk("sll1", {16'b0, out_data}, 32'h0010);
        chk("sll1_rd", {28'b0, out_rd}, 32'h3);
        step(1'b1, mk(4'h5, 4'h5, 4'd15), 16'h8000, 1'b0, 1'b1);
        chk("sra15", {16'b0, out_data}, 32'hFFFF);
        step(1'b1, mk(4'h6, 4'h7, 4'd4), 16'h1234, 1'b0, 1'b1);
        chk("ror4", {16'b0, out_data}, 32'h4123);
        chk("ror4_vld", {31'b0, out_valid}, 32'd1);
        step(1'b1, mk(4'h4, 4'h2, 4'd1), 16'h8000, 1'b0, 1'b1);
        chk("sll_zero", {16'b0, out_data}, 32'h0000);
        chk("sll_zero_z", {31'b0, z_flag}, 32'd1);
        step(1'b1, mk(4'h0, 4'h1, 4'd2), 16'h00FF, 1'b0, 1'b1);
        chk("bubble_vld", {31'b0, out_valid}, 32'd0);
        chk("bubble_z", {31'b0, z_flag}, 32'd1);
        step(1'b1, mk(4'h5, 4'h9, 4'd2), 16'hF000, 1'b0, 1'b1);
        chk("sra2", {16'b0, out_data}, 32'hFC00);

        // hold: slot full, downstream stalled, new op pending
        held_data = out_data;
        held_z    = z_flag;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(4'h4, 4'h4, 4'd3), 16'h0011, 1'b0, 1'b0);
            chk("hold_rdy", {31'b0, in_ready}, 32'd0);
            chk("hold_data", {16'b0, out_data}, {16'b0, held_data});
            chk("hold_z", {31'b0, z_flag}, {31'b0, held_z});
        end
        step(1'b1, mk(4'h4, 4'h4, 4'd3), 16'h0011, 1'b0, 1'b1);
        chk("release", {16'b0, out_data}, 32'h0088);

        // flush with incoming SRA that would have produced zero
        step(1'b1, mk(4'h5, 4'h1, 4'd3), 16'h0000, 1'b1, 1'b1);
        chk("flush_vld", {31'b0, out_valid}, 32'd0);
        chk("flush_z", {31'b0, z_flag}, 32'd0);

        // async reset mid-cycle with a zero result held
        step(1'b1, mk(4'h4, 4'h6, 4'd1), 16'h8000, 1'b0, 1'b0);
        chk("pre_rst_z", {31'b0, z_flag}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", {31'b0, out_valid}, 32'd0);
        chk("arst_z", {31'b0, z_flag}, 32'd0);
        m_vld = 1'b0; m_data = '0; m_rd = '0; m_z = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            case ($urandom_range(0, 3))
                0: op = 4'h4;
                1: op = 4'h5;
                2: op = 4'h6;
                default: op = 4'($urandom_range(0, 15));
            endcase
            step(($urandom_range(0, 3) != 0),
                 mk(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))),
                 (($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_ex_stage.md
Name: shift_ex_stage

Overview:
- Execute-stage wrapper around the 16-bit barrel Shifter.
- Decodes shift instructions (SLL/SRA/ROR) from the ID/EX payload and drives the Shifter's Mode and Shift_Val inputs.
- Registers the result, destination register and Z flag into a single-entry EX/MEM output slot.
- Upstream and downstream use valid/ready handshakes; flush support for branch squash.

Parameters:
- DATA_W, 16, datapath width; only 16 is supported (Shifter is fixed 16-bit).
- RID_W, 4, destination register index width.
- OP_SLL, 4'h4, opcode for SLL.
- OP_SRA, 4'h5, opcode for SRA.
- OP_ROR, 4'h6, opcode for ROR.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ID/EX payload valid.
- in_ready  output  1  stage can accept the payload this cycle.
- instr  input  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] imm4.
- rs_data  input  DATA_W  forwarded value of rs.
- flush  input  1  squash the held result and any incoming payload.
- out_valid  output  1  EX/MEM slot holds a result.
- out_ready  input  1  MEM stage consumes the slot this cycle.
- out_data  output  DATA_W  registered shift result.
- out_rd  output  RID_W  registered destination register.
- z_flag  output  1  zero flag of the last accepted shift.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n), clocked on clk rising edge.
- Reset values: out_valid=0, out_data=16'h0000, out_rd=0, z_flag=0. Reset has immediate effect, including mid-handshake; any held result is lost.
- Decode (combinational):
  - opcode OP_SLL: Mode=2'b00.
  - opcode OP_SRA: Mode=2'b01.
  - opcode OP_ROR: Mode=2'b10.
  - Shift_Val=instr[3:0]; Shift_In=rs_data.
  - is_shift = opcode is one of the three.
- in_ready = !out_valid | out_ready. It is combinational and does not depend on in_valid or instr.
- accept = in_valid & in_ready & is_shift & !flush.
- Non-shift opcodes with in_valid=1 are consumed as bubbles: in_ready behaves as above, nothing is written, and z_flag holds.
- Latency: one cycle. On an accept edge:
  - out_data <= Shifter output; out_rd <= instr[11:8]; out_valid <= 1.
  - z_flag <= (Shifter output == 0).
  - Result and flag become visible together in the following cycle.
- Hold: when out_valid=1 and out_ready=0, out_data, out_rd and z_flag are frozen and in_ready=0.
- Drain: when out_valid=1, out_ready=1 and no accept, the next edge sets out_valid <= 0. out_data and out_rd keep their stale values; the value is don't-care for verification.
- Simultaneous drain and accept: the slot is overwritten with the new result and out_valid stays 1 (back-to-back throughput of 1/cycle).
- Flush has priority over everything:
  - The next edge sets out_valid <= 0 and drops any incoming payload that cycle.
  - z_flag is not updated by a flushed payload; it holds its prior value.
- Shift semantics (inherited from Shifter):
  - SLL zero-fills.
  - SRA sign-fills from bit 15.
  - ROR rotates right modulo 16.
  - Shift amount 0 passes rs_data unchanged.
- No overflow or negative flags are produced by shifts. Only Z is driven.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants OP_SLL/OP_SRA/OP_ROR.
  - Mode encodings MODE_SLL=2'b00, MODE_SRA=2'b01, MODE_ROR=2'b10.
  - instruction field bit positions.
- One sub-module: the existing Shifter (ports Shift_In, Shift_Val, Mode, Shift_Out), instantiated unmodified.
- Decode logic and the output slot live in shift_ex_stage itself.

Test Plan:
- Reset then SLL, rs_data=16'h0001, imm4=4: next cycle out_valid=1, out_data=16'h0010, z_flag=0, out_rd=instr[11:8].
- SRA rs_data=16'h8000, imm4=15 -> out_data=16'hFFFF. Then ROR rs_data=16'h1234, imm4=4 back-to-back with out_ready=1 -> out_data=16'h4123 the next cycle, no bubble.
- SLL rs_data=16'h8000, imm4=1 -> out_data=16'h0000, z_flag=1. Following opcode 4'h0 with in_valid=1 -> out_valid drops after drain, z_flag stays 1.
- out_ready=0 for 3 cycles with out_valid=1 and a new in_valid pending: in_ready=0, and out_data/z_flag stable all 3 cycles. Releasing out_ready accepts the pending op the same cycle.
- flush=1 with out_valid=1 and an incoming SRA: next cycle out_valid=0, and z_flag equals its pre-flush value.
- Assert rst_n=0 asynchronously between edges while out_valid=1: out_valid=0 and z_flag=0 immediately, without waiting for a clock edge.
